// File: rtl/picorv32_mmio_hub.sv
// picorv32 native-bus slave: steers CPU cycles to a single-port RAM or to a small IO block
// (LEDs, synchronised switches, 7-seg digits, compare timer, W1C status driving irq).
module picorv32_mmio_hub #(
    parameter int unsigned RAM_BYTES  = 8192,
    parameter int unsigned RAM_LAT    = 1,
    parameter logic [31:0] IO_BASE    = 32'h8000,
    parameter int unsigned LED_W      = 8,
    parameter int unsigned SW_W       = 8,
    parameter int unsigned HEX_DIGITS = 6
) (
    input  logic                    sys_clk,
    input  logic                    sys_resetn,
    input  logic                    mem_valid,
    input  logic [31:0]             mem_addr,
    input  logic [31:0]             mem_wdata,
    input  logic [3:0]              mem_wstrb,
    output logic                    mem_ready,
    output logic [31:0]             mem_rdata,
    output logic                    ram_rden,
    output logic                    ram_wren,
    input  logic [31:0]             ram_rdata,
    output logic [LED_W-1:0]        LEDR,
    input  logic [SW_W-1:0]         SW,
    output logic [7*HEX_DIGITS-1:0] hex_seg,
    output logic                    irq
);
    localparam int unsigned HEX_W  = 4 * HEX_DIGITS;
    localparam logic [1:0]  LAT_M1 = 2'(RAM_LAT - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

    state_e             state_q, state_d;
    logic [1:0]         cnt_q, cnt_d;
    logic               wr_q, wr_d;
    logic               ready_q, ready_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [LED_W-1:0]   led_q, led_d;
    logic [SW_W-1:0]    sw_s1_q, sw_s2_q, sw_prev_q;
    logic [2:0]         status_q, status_d, irq_en_q, irq_en_d, w1c;
    logic [HEX_W-1:0]   hex_q, hex_d;
    logic [31:0]        tmr_cnt_q, tmr_cnt_d, tmr_cmp_q, tmr_cmp_d;
    logic               tmr_en_q, tmr_en_d, tmr_clr, tmr_match;
    logic               irq_q;
    logic               req, is_wr, io_hit, ram_hit, io_we, bus_err, ram_rd_c, ram_wr_c;
    logic [31:0]        io_off, wmask, io_rdata;
    logic [2:0]         io_idx;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [31:0] m);
        return (old & ~m) | (wd & m);
    endfunction

    // Active-low {g..a} hex font
    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
        endcase
    endfunction

    assign is_wr   = |mem_wstrb;
    assign io_off  = mem_addr - IO_BASE;
    assign io_hit  = io_off < 32'd32;
    assign io_idx  = io_off[4:2];
    assign ram_hit = mem_addr < RAM_BYTES;
    assign req     = (state_q == S_IDLE) && mem_valid && !ready_q;
    assign wmask   = {{8{mem_wstrb[3]}}, {8{mem_wstrb[2]}}, {8{mem_wstrb[1]}}, {8{mem_wstrb[0]}}};

    always_comb begin
        case (io_idx)
            3'd0:    io_rdata = 32'(led_q);
            3'd1:    io_rdata = 32'(sw_s2_q);
            3'd2:    io_rdata = {29'd0, status_q};
            3'd3:    io_rdata = {29'd0, irq_en_q};
            3'd4:    io_rdata = 32'(hex_q);
            3'd5:    io_rdata = tmr_cnt_q;
            3'd6:    io_rdata = tmr_cmp_q;
            default: io_rdata = {31'd0, tmr_en_q};
        endcase
    end

    // The RAM strobes are issued straight from the decode cycle so RAM_LAT counts from there.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_d     = wr_q;
        ready_d  = 1'b0;
        rdata_d  = rdata_q;
        ram_rd_c = 1'b0;
        ram_wr_c = 1'b0;
        io_we    = 1'b0;
        bus_err  = 1'b0;
        case (state_q)
            S_IDLE: if (req) begin
                wr_d  = is_wr;
                cnt_d = 2'd0;
                if (ram_hit) begin
                    ram_rd_c = !is_wr;
                    ram_wr_c = is_wr;
                    state_d  = S_WAIT;
                end else begin
                    state_d = S_DONE;
                    ready_d = 1'b1;
                    if (io_hit) begin
                        io_we = is_wr;
                        if (!is_wr) rdata_d = io_rdata;
                    end else begin
                        bus_err = 1'b1;
                        rdata_d = 32'd0;
                    end
                end
            end
            S_WAIT: begin
                if (wr_q) begin
                    state_d = S_DONE;
                    ready_d = 1'b1;
                end else if (cnt_q == LAT_M1) begin
                    rdata_d = ram_rdata;
                    state_d = S_DONE;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        led_d     = led_q;
        irq_en_d  = irq_en_q;
        hex_d     = hex_q;
        tmr_cmp_d = tmr_cmp_q;
        tmr_en_d  = tmr_en_q;
        tmr_clr   = 1'b0;
        w1c       = 3'd0;
        if (io_we) begin
            case (io_idx)
                3'd0: led_d     = LED_W'(merge(32'(led_q), mem_wdata, wmask));
                3'd2: w1c       = mem_wdata[2:0] & {3{mem_wstrb[0]}};
                3'd3: irq_en_d  = 3'(merge({29'd0, irq_en_q}, mem_wdata, wmask));
                3'd4: hex_d     = HEX_W'(merge(32'(hex_q), mem_wdata, wmask));
                3'd6: tmr_cmp_d = merge(tmr_cmp_q, mem_wdata, wmask);
                3'd7: if (mem_wstrb[0]) begin
                    tmr_en_d = mem_wdata[0];
                    tmr_clr  = mem_wdata[1];
                end
                default: ;
            endcase
        end
        tmr_match = 1'b0;
        tmr_cnt_d = tmr_cnt_q;
        if (tmr_clr) begin
            tmr_cnt_d = 32'd0;
        end else if (tmr_en_q) begin
            if (tmr_cnt_q == tmr_cmp_q) begin
                tmr_cnt_d = 32'd0;
                tmr_match = 1'b1;
            end else begin
                tmr_cnt_d = tmr_cnt_q + 32'd1;
            end
        end
        // Hardware sets are OR-ed after the clear so a coincident set survives a W1C
        status_d = (status_q & ~w1c) | {bus_err, tmr_match, sw_s2_q != sw_prev_q};
    end

    always_ff @(posedge sys_clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            state_q   <= S_IDLE;
            cnt_q     <= 2'd0;
            wr_q      <= 1'b0;
            ready_q   <= 1'b0;
            rdata_q   <= 32'd0;
            led_q     <= '0;
            sw_s1_q   <= '0;
            sw_s2_q   <= '0;
            sw_prev_q <= '0;
            status_q  <= 3'd0;
            irq_en_q  <= 3'd0;
            hex_q     <= '0;
            tmr_cnt_q <= 32'd0;
            tmr_cmp_q <= 32'hFFFF_FFFF;
            tmr_en_q  <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            ready_q   <= ready_d;
            rdata_q   <= rdata_d;
            led_q     <= led_d;
            sw_s1_q   <= SW;
            sw_s2_q   <= sw_s1_q;
            sw_prev_q <= sw_s2_q;
            status_q  <= status_d;
            irq_en_q  <= irq_en_d;
            hex_q     <= hex_d;
            tmr_cnt_q <= tmr_cnt_d;
            tmr_cmp_q <= tmr_cmp_d;
            tmr_en_q  <= tmr_en_d;
            irq_q     <= |(status_q & irq_en_q);
        end
    end

    for (genvar g = 0; g < HEX_DIGITS; g++) begin : g_digit
        assign hex_seg[7*g +: 7] = seg7(hex_q[4*g +: 4]);
    end

    assign mem_ready = ready_q;
    assign mem_rdata = rdata_q;
    assign ram_rden  = ram_rd_c & sys_resetn;
    assign ram_wren  = ram_wr_c & sys_resetn;
    assign LEDR      = led_q;
    assign irq       = irq_q;
endmodule
